// File: rtl/nvme_ioq_mux.sv
// Multi-queue NVMe submission multiplexer: per-queue FIFOs, round-robin arbiter,
// per-queue modulo SQ tail counters and a single registered valid/ready output.
module nvme_ioq_mux #(
  parameter int unsigned NUM_Q      = 4,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SQ_ENTRIES = 64,
  localparam int unsigned QW = (NUM_Q > 1) ? $clog2(NUM_Q) : 1,
  localparam int unsigned TW = $clog2(SQ_ENTRIES)
) (
  input  logic                        user_clk,
  input  logic                        user_reset_n,
  input  logic                        user_lnk_up,
  input  logic [NUM_Q*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_Q-1:0]            in_valid,
  output logic [NUM_Q-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [QW-1:0]               out_qid,
  output logic [TW-1:0]               out_sq_tail,
  output logic [NUM_Q-1:0]            q_empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TAIL_MAX = TW'(SQ_ENTRIES - 1);
  localparam logic [QW-1:0] LAST_Q   = QW'(NUM_Q - 1);

  logic [DATA_WIDTH-1:0] mem    [NUM_Q][FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr [NUM_Q];
  logic [AW-1:0]         rd_ptr [NUM_Q];
  logic [CW-1:0]         cnt    [NUM_Q];
  logic [TW-1:0]         tail   [NUM_Q];
  logic [QW-1:0]         rr_ptr;

  logic [NUM_Q-1:0] full;
  logic [NUM_Q-1:0] nonempty;
  logic [NUM_Q-1:0] push;
  logic [NUM_Q-1:0] pop;
  logic [QW-1:0]    grant;
  logic             grant_vld;
  logic             load;
  logic [TW-1:0]    tail_nxt;

  // Occupancy decode from registered counts only
  always_comb begin
    full     = '0;
    nonempty = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      full[i]     = (cnt[i] == FULL_CNT);
      nonempty[i] = (cnt[i] != '0);
    end
  end

  assign in_ready = {NUM_Q{user_lnk_up}} & ~full;
  assign q_empty  = ~nonempty;
  assign push     = in_valid & in_ready;

  // Round-robin scan starting at rr_ptr
  always_comb begin
    logic [QW-1:0] idx;
    idx       = '0;
    grant     = '0;
    grant_vld = 1'b0;
    for (int k = 0; k < NUM_Q; k++) begin
      idx = QW'((32'(rr_ptr) + 32'(k)) % NUM_Q);
      if (!grant_vld && nonempty[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  assign load     = grant_vld & (~out_valid | out_ready);
  assign tail_nxt = (tail[grant] == TAIL_MAX) ? '0 : tail[grant] + TW'(1);

  always_comb begin
    pop = '0;
    if (load) pop[grant] = 1'b1;
  end

  // Entry storage, no reset needed: validity is tracked by the counts
  always_ff @(posedge user_clk) begin
    for (int i = 0; i < NUM_Q; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // FIFO pointers, counts, tails and arbiter pointer; flush overrides all traffic
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      for (int i = 0; i < NUM_Q; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
        tail[i]   <= '0;
      end
      rr_ptr <= '0;
    end else if (!user_lnk_up) begin
      for (int i = 0; i < NUM_Q; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
        tail[i]   <= '0;
      end
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < NUM_Q; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + CW'(1);
          2'b01:   cnt[i] <= cnt[i] - CW'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
      if (load) begin
        tail[grant] <= tail_nxt;
        rr_ptr      <= (grant == LAST_Q) ? '0 : grant + QW'(1);
      end
    end
  end

  // Output slot: loads when free or being consumed, holds under back-pressure
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_qid     <= '0;
      out_sq_tail <= '0;
    end else if (!user_lnk_up) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_data    <= mem[grant][rd_ptr[grant]];
      out_qid     <= grant;
      out_sq_tail <= tail_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
